// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  // Sequencer state: normal issue, or frozen behind a multi-cycle EX op.
  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } state_e;

  localparam int MC_LATENCY_DEF  = 4;
  localparam int MEM_TIMEOUT_DEF = 255;
  localparam int REG_IDX_W       = 5;
  localparam int STALL_CNT_W     = 32;
  localparam int MC_CNT_W        = 4;
  localparam int WAIT_CNT_W      = 8;

  // Saturating increment for the memory wait counter.
  function automatic logic [WAIT_CNT_W-1:0] sat_inc_wait(input logic [WAIT_CNT_W-1:0] v);
    if (v == 8'hFF) begin
      sat_inc_wait = v;
    end else begin
      sat_inc_wait = v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: the ID instruction reads a register that the load in EX writes.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                 ex_memread,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  output logic                 lu
);

  // x0 is never a real dependency, so a load to x0 never stalls.
  always_comb begin
    lu = 1'b0;
    if (ex_memread && (ex_rd != 5'd0)) begin
      lu = (id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd));
    end else begin
      lu = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch flush,
// multi-cycle EX freeze and data-memory wait states.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_LATENCY  = MC_LATENCY_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_IDX_W-1:0]   id_rs1,
  input  logic [REG_IDX_W-1:0]   id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic [REG_IDX_W-1:0]   ex_rd,
  input  logic                   ex_memread,
  input  logic                   ex_branch_taken,
  input  logic                   ex_mc_op,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   id_ex_write,
  output logic                   ex_mem_write,
  output logic                   mem_wb_write,
  output logic                   id_ex_bubble,
  output logic                   ex_mem_bubble,
  output logic                   mem_wb_bubble,
  output logic                   if_id_flush,
  output logic                   busy_state,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic                   mem_timeout
);

  localparam logic [MC_CNT_W-1:0]   MC_RELOAD = MC_CNT_W'(MC_LATENCY - 2);
  // Timeout fires on the wait cycle that brings the count up to MEM_TIMEOUT.
  localparam logic [WAIT_CNT_W-1:0] TO_LAST   = WAIT_CNT_W'(MEM_TIMEOUT - 1);

  state_e                 state_r, state_nxt_s;
  logic [MC_CNT_W-1:0]    mc_cnt_r, mc_cnt_nxt_s;
  logic [WAIT_CNT_W-1:0]  wait_cnt_r;
  logic [STALL_CNT_W-1:0] stall_count_r;
  logic                   mem_timeout_r;
  logic                   lu_s;
  logic                   ms_s;
  logic                   run_decode_s;

  load_use_detect u_lu (
    .ex_memread  (ex_memread),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .lu          (lu_s)
  );

  assign ms_s        = mem_req && !mem_ready;
  assign stall_count = stall_count_r;
  assign mem_timeout = mem_timeout_r;

  // Output decode and next-state logic; priority ms > MC freeze > branch > load-use.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    mem_wb_write  = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_bubble = 1'b0;
    if_id_flush   = 1'b0;
    busy_state    = 1'b0;
    state_nxt_s   = state_r;
    mc_cnt_nxt_s  = mc_cnt_r;
    run_decode_s  = 1'b0;

    if (reset) begin
      // Everything writes so the pipeline registers clear themselves.
      state_nxt_s  = RUN;
      mc_cnt_nxt_s = 4'd0;
    end else if (ms_s) begin
      // Whole pipe frozen; a bubble drains into WB. State and mc_cnt hold.
      busy_state    = (state_r == MC_BUSY);
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else begin
      busy_state = (state_r == MC_BUSY);
      case (state_r)
        RUN: begin
          if (ex_mc_op) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
            mc_cnt_nxt_s  = MC_RELOAD;
            state_nxt_s   = MC_BUSY;
          end else begin
            run_decode_s = 1'b1;
          end
        end
        MC_BUSY: begin
          if (mc_cnt_r != 4'd0) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
            mc_cnt_nxt_s  = mc_cnt_r - 4'd1;
          end else begin
            // Release cycle: the op leaves EX, branch and load-use still apply.
            state_nxt_s  = RUN;
            run_decode_s = 1'b1;
          end
        end
        default: begin
          state_nxt_s  = RUN;
          mc_cnt_nxt_s = 4'd0;
        end
      endcase

      if (run_decode_s) begin
        if (ex_branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (lu_s) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end else begin
          id_ex_bubble = 1'b0;
        end
      end else begin
        run_decode_s = 1'b0;
      end
    end
  end

  // FSM state and multi-cycle countdown register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= RUN;
      mc_cnt_r <= 4'd0;
    end else begin
      state_r  <= state_nxt_s;
      mc_cnt_r <= mc_cnt_nxt_s;
    end
  end

  // Memory wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_r    <= 8'd0;
      mem_timeout_r <= 1'b0;
    end else if (ms_s) begin
      wait_cnt_r <= sat_inc_wait(wait_cnt_r);
      if (wait_cnt_r >= TO_LAST) begin
        mem_timeout_r <= 1'b1;
      end
    end else begin
      wait_cnt_r <= 8'd0;
    end
  end

  // Stall-cycle counter: counts every cycle the PC is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_r <= 32'd0;
    end else if (!pc_write) begin
      stall_count_r <= stall_count_r + 32'd1;
    end
  end

endmodule
